// File: rtl/adder_sched_pkg.sv
// Shared types and the round-robin grant function for adder_sched and other arbiters.
package adder_sched_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam int STAT_WIDTH = 32;
  localparam int RR_MAX     = 16;

  // One-hot grant: first set bit of req searching upward from last+1, wrapping at n.
  function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                input int unsigned last,
                                                input int unsigned n);
    logic [RR_MAX-1:0] g;
    logic              found;
    logic [3:0]        idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = 4'((last + k) % n);
      if (k <= n && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter; the last-grant pointer lives in the caller.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant_oh,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic [RR_MAX-1:0] full_oh;
  logic              unused_hi;

  assign full_oh   = rr_next(RR_MAX'(req), 32'(last_grant), NUM_REQ);
  assign unused_hi = ^full_oh;
  assign grant_oh  = en ? full_oh[NUM_REQ-1:0] : '0;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_oh[i]) grant_idx = ID_WIDTH'(i);
  end

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one adder among NUM_REQ requesters.
// Define ADDER_SCHED_STATS_EN to add saturating op_count / carry_count outputs.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [ID_WIDTH-1:0]                rsp_id,
  output logic [DATA_WIDTH:0]                rsp_sum
`ifdef ADDER_SCHED_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]              op_count,
  output logic [STAT_WIDTH-1:0]              carry_count
`endif
);

  state_e                state, state_nxt;
  logic [ID_WIDTH-1:0]   last_grant, grant_idx;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic                  free, accept;

  // Output slot frees up in the same cycle its result is consumed.
  assign free = (state == IDLE) || rsp_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .en        (free && !rst),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  assign accept    = |grant_oh;
  assign req_ready = grant_oh;
  assign rsp_valid = (state == BUSY);
  assign rsp_sum   = {1'b0, op_a} + {1'b0, op_b};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                          state_nxt = BUSY;
    else if (state == BUSY && rsp_ready) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      rsp_id     <= '0;
    end else if (accept) begin
      last_grant <= grant_idx;
      op_a       <= req_a[grant_idx];
      op_b       <= req_b[grant_idx];
      rsp_id     <= grant_idx;
    end
  end

`ifdef ADDER_SCHED_STATS_EN
  logic done;
  assign done = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count    <= '0;
      carry_count <= '0;
    end else if (done) begin
      if (op_count != '1) op_count <= op_count + 1'b1;
      if (rsp_sum[DATA_WIDTH] && carry_count != '1) carry_count <= carry_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched: per-cycle grant model plus directed scenario tasks.
module tb_adder_sched;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NR-1:0]         req_valid = '0;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0][DW-1:0] req_a = '0;
  logic [NR-1:0][DW-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IW-1:0]         rsp_id;
  logic [DW:0]           rsp_sum;
`ifdef ADDER_SCHED_STATS_EN
  logic [31:0]           op_count, carry_count;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rsp3 = 0;
  int          q_id[$];
  logic [DW:0] q_sum[$];
  logic        m_busy = 1'b0;
  int          m_last = NR - 1;

  always #5 clk = ~clk;

  adder_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum)
`ifdef ADDER_SCHED_STATS_EN
    ,
    .op_count   (op_count),
    .carry_count(carry_count)
`endif
  );

  // Reference model, evaluated mid-cycle with inputs stable, advanced for the next edge.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic [DW:0]   esum;
    int            g, eid;
    exp_rdy = '0;
    g = -1;
    if (!rst && (!m_busy || rsp_ready))
      for (int k = 1; k <= NR; k++)
        if (g < 0 && req_valid[(m_last + k) % NR]) g = (m_last + k) % NR;
    if (g >= 0) exp_rdy[g] = 1'b1;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL sb_req_ready t=%0t got=%b exp=%b", $time, req_ready, exp_rdy);
    end
    n_cmp++;
    if (rsp_valid !== m_busy) begin
      n_err++;
      $display("FAIL sb_rsp_valid t=%0t got=%b exp=%b", $time, rsp_valid, m_busy);
    end
    if (rst) begin
      m_busy = 1'b0;
      m_last = NR - 1;
      q_id.delete();
      q_sum.delete();
    end else begin
      if (m_busy && rsp_ready) begin
        n_cmp++;
        if (q_id.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow t=%0t got=response exp=none", $time);
        end else begin
          eid  = q_id.pop_front();
          esum = q_sum.pop_front();
          if (rsp_id !== IW'(eid) || rsp_sum !== esum) begin
            n_err++;
            $display("FAIL sb_rsp t=%0t got id=%0d sum=%h exp id=%0d sum=%h",
                     $time, rsp_id, rsp_sum, eid, esum);
          end
          if (eid == 3) n_rsp3++;
        end
      end
      if (g >= 0) begin
        q_id.push_back(g);
        q_sum.push_back({1'b0, req_a[g]} + {1'b0, req_b[g]});
        m_last = g;
        m_busy = 1'b1;
      end else if (rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== '0 || req_ready !== '0) begin
      n_err++;
      $display("FAIL reset_state got v=%b id=%0d sum=%h rdy=%b exp 0/0/000/0000",
               rsp_valid, rsp_id, rsp_sum, req_ready);
    end
`ifdef ADDER_SCHED_STATS_EN
    n_cmp++;
    if (op_count !== 32'd0 || carry_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_stats got %0d/%0d exp 0/0", op_count, carry_count);
    end
`endif
    cyc();
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[0] = 8'h12;
    req_b[0] = 8'h34;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL basic_ready got=%b exp=0001", req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 9'h046) begin
      n_err++;
      $display("FAIL basic_rsp got v=%b id=%0d sum=%h exp 1/0/046", rsp_valid, rsp_id, rsp_sum);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle got=%b exp=0", rsp_valid);
    end
    cyc();
  endtask

  task automatic test_carry();
    req_valid = 4'b0100;
    req_a[2] = 8'hFF;
    req_b[2] = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL carry_ready got=%b exp=0100", req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_sum !== 9'h1FE || rsp_id !== 2'd2) begin
      n_err++;
      $display("FAIL carry_rsp got id=%0d sum=%h exp 2/1fe", rsp_id, rsp_sum);
    end
    cyc();
`ifdef ADDER_SCHED_STATS_EN
    @(negedge clk);
    n_cmp++;
    if (carry_count !== 32'd1 || op_count !== 32'd2) begin
      n_err++;
      $display("FAIL carry_stats got %0d/%0d exp ops=2 carries=1", op_count, carry_count);
    end
    cyc();
`endif
  endtask

  task automatic test_rr();
    int ord[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_a = {8'hF0, 8'h80, 8'h40, 8'h01};
    req_b = {8'h20, 8'h90, 8'hC0, 8'h02};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'(1 << ord[i])) begin
        n_err++;
        $display("FAIL rr_order step=%0d got=%b exp=%b", i, req_ready, 4'(1 << ord[i]));
      end
      if (i > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
          n_err++;
          $display("FAIL rr_throughput step=%0d got=%b exp=1", i, rsp_valid);
        end
      end
      cyc();
    end
    req_valid = '0;
    @(negedge clk);
    cyc();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a[0] = 8'h12; req_b[0] = 8'h34;
    req_a[1] = 8'h56; req_b[1] = 8'h78;
    req_a[3] = 8'h9A; req_b[3] = 8'hBC;
    req_valid = 4'b0001;
    @(negedge clk);
    cyc();
    req_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 9'h046) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b id=%0d sum=%h exp 0000/1/0/046",
                 i, req_ready, rsp_valid, rsp_id, rsp_sum);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_release got=%b exp=0010", req_ready);
    end
    cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (rsp_id !== 2'd1 || rsp_sum !== 9'h0CE || req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL bp_next got id=%0d sum=%h rdy=%b exp 1/0ce/1000", rsp_id, rsp_sum, req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_id !== 2'd3 || rsp_sum !== 9'h156) begin
      n_err++;
      $display("FAIL bp_last got id=%0d sum=%h exp 3/156", rsp_id, rsp_sum);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_a[1] = 8'h56; req_b[1] = 8'h78;
    req_valid = 4'b0010;
    @(negedge clk);
    cyc();
    req_valid = '0;
    @(negedge clk);
    cyc();
    rst = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_during got rdy=%b v=%b exp 0000/1", req_ready, rsp_valid);
    end
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 9'h000 || req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_after got v=%b sum=%h rdy=%b exp 0/000/0001", rsp_valid, rsp_sum, req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    cyc();
  endtask

  task automatic test_toggle();
    do_reset();
    rsp_ready = 1'b1;
    n_rsp3 = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      req_a[3] = 8'(i * 37 + 11);
      req_b[3] = 8'(250 - i * 13);
      @(negedge clk);
      n_cmp++;
      if (req_ready !== req_valid) begin
        n_err++;
        $display("FAIL toggle_ready step=%0d got=%b exp=%b", i, req_ready, req_valid);
      end
      cyc();
    end
    req_valid = '0;
    cyc();
    cyc();
    @(negedge clk);
    n_cmp++;
    if (n_rsp3 != 4 || q_id.size() != 0) begin
      n_err++;
      $display("FAIL toggle_count got rsp=%0d pending=%0d exp 4/0", n_rsp3, q_id.size());
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_rr();
    test_backpressure();
    test_reset_mid();
    test_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
